// File: rtl/seat_req.sv
// seat_req: buffers seat-change requests, runs check-then-write against the seat memory, and keeps the minute-of-day clock
//   clk_seat_req, rst_seat_req             clock, synchronous active-high reset
//   req_valid, req_ready, req_seat_no,
//   req_state                              request handshake into a FIFO_DEPTH-entry FIFO
//   Do_Not_Seat                            conflict flag returned by the memory stage
//   write_mem2, Time_mem2, Seat_State_mem2,
//   Seat_No_mem2                           memory write port; Time_mem2 is the minute of day
//   limit_time                             away-state timeout in minutes
//   resp_valid, resp_code, resp_seat_no    one-cycle response per request
module seat_req #(
   parameter int NUM_SEATS     = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int TICKS_PER_MIN = 3000,
   parameter int AWAY_LIMIT    = 30
) (
   input  logic        clk_seat_req,
   input  logic        rst_seat_req,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_seat_no,
   input  logic [1:0]  req_state,
   input  logic        Do_Not_Seat,
   output logic        write_mem2,
   output logic [10:0] Time_mem2,
   output logic [1:0]  Seat_State_mem2,
   output logic [7:0]  Seat_No_mem2,
   output logic [10:0] limit_time,
   output logic        resp_valid,
   output logic [1:0]  resp_code,
   output logic [7:0]  resp_seat_no
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(TICKS_PER_MIN + 1);
   // REJECT is the single idle cycle a bad seat spends before its response
   typedef enum logic [2:0] {IDLE, CHECK, SAMPLE, WRITE, RESP, REJECT} state_e;
   state_e state_q, state_d;
   logic [9:0] fifo_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic ready_q;
   logic [PW-1:0] presc_q;
   logic [10:0] min_q;
   logic [7:0] seat_q, mem_seat_q, resp_seat_q;
   logic [1:0] st_q, mem_st_q, code_q, code_d, resp_code_q;
   logic [7:0] head_seat;
   logic [1:0] head_st;
   logic push, pop, bad, conflict, tick;
   assign head_seat = fifo_q[rd_q][9:2];
   assign head_st = fifo_q[rd_q][1:0];
   assign push = req_valid && ready_q;
   assign pop = (state_q == IDLE) && (cnt_q != '0);
   assign bad = {1'b0, head_seat} >= 9'(NUM_SEATS);
   assign conflict = Do_Not_Seat && (st_q == 2'd3);
   assign tick = presc_q == PW'(TICKS_PER_MIN - 1);
   assign cnt_d = cnt_q + CW'(push) - CW'(pop);
   assign req_ready = ready_q;
   assign Time_mem2 = min_q;
   assign Seat_No_mem2 = mem_seat_q;
   assign Seat_State_mem2 = mem_st_q;
   assign limit_time = 11'(AWAY_LIMIT);
   assign resp_code = resp_code_q;
   assign resp_seat_no = resp_seat_q;
   always_ff @(posedge clk_seat_req) begin
      if (rst_seat_req) begin
         state_q <= IDLE;
         code_q <= '0;
      end else begin
         state_q <= state_d;
         code_q <= code_d;
      end
   end
   always_comb begin
      state_d = state_q;
      code_d = code_q;
      case (state_q)
         IDLE: if (pop) begin
            state_d = bad ? REJECT : CHECK;
            code_d = bad ? 2'b10 : 2'b00;
         end
         CHECK: state_d = SAMPLE;
         SAMPLE: begin
            state_d = conflict ? RESP : WRITE;
            code_d = conflict ? 2'b01 : 2'b00;
         end
         WRITE, REJECT: state_d = RESP;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      write_mem2 = state_q == WRITE;
      resp_valid = state_q == RESP;
   end
   always_ff @(posedge clk_seat_req) begin
      if (push) fifo_q[wr_q] <= {req_seat_no, req_state};
   end
   always_ff @(posedge clk_seat_req) begin
      if (rst_seat_req) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
         ready_q <= 1'b1;
         presc_q <= '0;
         min_q <= '0;
         seat_q <= '0;
         st_q <= '0;
         mem_seat_q <= '0;
         mem_st_q <= '0;
         resp_code_q <= '0;
         resp_seat_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         ready_q <= cnt_d < CW'(FIFO_DEPTH);
         presc_q <= tick ? '0 : presc_q + 1'b1;
         if (tick) min_q <= (min_q == 11'd1439) ? '0 : min_q + 1'b1;
         if (push) wr_q <= wr_q + 1'b1;
         if (pop) begin
            rd_q <= rd_q + 1'b1;
            seat_q <= head_seat;
            st_q <= head_st;
         end
         // memory port only ever shows seats that passed the range check
         if (pop && !bad) begin
            mem_seat_q <= head_seat;
            mem_st_q <= head_st;
         end
         if (state_d == RESP && state_q != RESP) begin
            resp_code_q <= code_d;
            resp_seat_q <= seat_q;
         end
      end
   end
endmodule

// File: tb/tb_seat_req.sv
// tb_seat_req: scoreboard bench for seat_req with directed requests
module tb_seat_req;
   logic clk = 0;
   logic rst_seat_req, req_valid, req_ready, Do_Not_Seat, write_mem2, resp_valid;
   logic [7:0] req_seat_no, Seat_No_mem2, resp_seat_no;
   logic [1:0] req_state, Seat_State_mem2, resp_code;
   logic [10:0] Time_mem2, limit_time;
   int checks = 0, errors = 0, k = 0, cyc = 0, w;
   logic [9:0] rq[$], wq[$];
   logic [9:0] re, we;
   int rtimes[$];
   seat_req #(.NUM_SEATS(32), .FIFO_DEPTH(4), .TICKS_PER_MIN(4), .AWAY_LIMIT(30)) dut (
      .clk_seat_req(clk), .rst_seat_req(rst_seat_req), .req_valid(req_valid), .req_ready(req_ready),
      .req_seat_no(req_seat_no), .req_state(req_state), .Do_Not_Seat(Do_Not_Seat),
      .write_mem2(write_mem2), .Time_mem2(Time_mem2), .Seat_State_mem2(Seat_State_mem2),
      .Seat_No_mem2(Seat_No_mem2), .limit_time(limit_time), .resp_valid(resp_valid),
      .resp_code(resp_code), .resp_seat_no(resp_seat_no)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      k <= rst_seat_req ? 0 : k + 1;
   end
   always @(negedge clk) begin
      if (resp_valid) begin
         checks++;
         rtimes.push_back(cyc);
         if (rq.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: got code %0d seat %0d, expected no response", resp_code, resp_seat_no);
         end else begin
            re = rq.pop_front();
            if ({resp_code, resp_seat_no} !== re) begin
               errors++;
               $display("FAIL resp: got code %0d seat %0d, expected code %0d seat %0d", resp_code, resp_seat_no, re[9:8], re[7:0]);
            end
         end
      end
      if (write_mem2) begin
         checks++;
         if (wq.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got seat %0d state %0d, expected no write", Seat_No_mem2, Seat_State_mem2);
         end else begin
            we = wq.pop_front();
            if ({Seat_No_mem2, Seat_State_mem2, Time_mem2} !== {we, 11'((k / 4) % 1440)}) begin
               errors++;
               $display("FAIL write: got seat %0d state %0d time %0d, expected seat %0d state %0d time %0d",
                        Seat_No_mem2, Seat_State_mem2, Time_mem2, we[9:2], we[1:0], (k / 4) % 1440);
            end
         end
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic push(input logic [7:0] s, input logic [1:0] st, input logic [1:0] code, input bit exp, output int n);
      n = 0;
      req_valid = 1;
      req_seat_no = s;
      req_state = st;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: req_ready got 0 expected 1");
      end else begin
         if (exp) begin
            rq.push_back({code, s});
            if (code == 2'b00) wq.push_back({s, st});
         end
         @(negedge clk);
      end
      req_valid = 0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL drain_timeout: got %0d outstanding expected 0", rq.size() + wq.size());
         rq.delete();
         wq.delete();
      end
      @(negedge clk);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      rst_seat_req = 1;
      req_valid = 0;
      req_seat_no = 0;
      req_state = 0;
      Do_Not_Seat = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_write", write_mem2, 0);
      chk("rst_resp", resp_valid, 0);
      chk("rst_resp_fields", {resp_code, resp_seat_no}, 0);
      chk("rst_mem_fields", {Seat_No_mem2, Seat_State_mem2}, 0);
      chk("rst_time", Time_mem2, 0);
      chk("limit_time", limit_time, 30);
      rst_seat_req = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk("time_tick", Time_mem2, 32'(i / 4));
      end
      // single ok request with latency probe
      push(8'd5, 2'd3, 2'b00, 1, w);
      @(negedge clk);
      chk("check_seat", Seat_No_mem2, 5);
      chk("check_nowrite", write_mem2, 0);
      @(negedge clk);
      chk("sample_nowrite", write_mem2, 0);
      @(negedge clk);
      chk("write_pulse", {write_mem2, Seat_No_mem2, Seat_State_mem2}, {1'b1, 8'd5, 2'd3});
      @(negedge clk);
      chk("resp_pulse", {resp_valid, write_mem2, resp_code}, {1'b1, 1'b0, 2'b00});
      wait_idle();
      // conflict only when already seated
      Do_Not_Seat = 1;
      push(8'd7, 2'd3, 2'b01, 1, w);
      wait_idle();
      push(8'd6, 2'd1, 2'b00, 1, w);
      wait_idle();
      Do_Not_Seat = 0;
      // out-of-range seat skips the memory sequence
      push(8'd40, 2'd2, 2'b10, 1, w);
      @(negedge clk);
      chk("bad_noresp_yet", {resp_valid, write_mem2}, 0);
      chk("bad_mem_hold", Seat_No_mem2, 6);
      @(negedge clk);
      chk("bad_resp", {resp_valid, resp_code, resp_seat_no}, {1'b1, 2'b10, 8'd40});
      wait_idle();
      push(8'd31, 2'd0, 2'b00, 1, w);
      wait_idle();
      // fill the FIFO while busy
      rtimes.delete();
      push(8'd10, 2'd0, 2'b00, 1, w);
      push(8'd11, 2'd2, 2'b00, 1, w);
      push(8'd12, 2'd3, 2'b00, 1, w);
      push(8'd13, 2'd1, 2'b00, 1, w);
      push(8'd14, 2'd0, 2'b00, 1, w);
      chk("full_ready", req_ready, 0);
      push(8'd15, 2'd3, 2'b00, 1, w);
      chk("held_off", w > 0, 1);
      wait_idle();
      chk("burst_resp_count", rtimes.size(), 6);
      for (int i = 1; i < 6 && i < rtimes.size(); i++) chk("resp_spacing", rtimes[i] - rtimes[i-1], 5);
      // reset mid-sequence drops queued work
      push(8'd20, 2'd3, 2'b00, 0, w);
      push(8'd21, 2'd3, 2'b00, 0, w);
      push(8'd22, 2'd3, 2'b00, 0, w);
      rst_seat_req = 1;
      @(negedge clk);
      rst_seat_req = 0;
      chk("midrst_ready", req_ready, 1);
      chk("midrst_outs", {write_mem2, resp_valid}, 0);
      chk("midrst_time", Time_mem2, 0);
      repeat (15) @(negedge clk);
      push(8'd23, 2'd2, 2'b00, 1, w);
      wait_idle();
      // minute counter rollover
      for (int n = 0; n < 8000 && k != 5759; n++) @(negedge clk);
      chk("time_1439", Time_mem2, 1439);
      @(negedge clk);
      chk("time_wrap", Time_mem2, 0);
      chk("queues_empty", rq.size() + wq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
